// File: rtl/spi_apb_txn_sequencer.sv
// APB master that programs the SPI controller at start-up, then arbitrates two
// byte-transfer requesters onto it (write DR, poll SR for SPIF, read DR).
module spi_apb_txn_sequencer #(
   parameter logic [7:0] CR1_INIT   = 8'hFB,
   parameter logic [7:0] CR2_INIT   = 8'hD0,
   parameter logic [7:0] BR_INIT    = 8'h01,
   parameter int         POLL_LIMIT = 1024
) (
   input  logic       PCLK,
   input  logic       PRESET_n,
   input  logic [1:0] req_i,
   input  logic [7:0] tx0_i,
   input  logic [7:0] tx1_i,
   output logic [1:0] gnt_o,
   output logic [1:0] done_o,
   output logic [7:0] rx_data_o,
   output logic       err_o,
   output logic       cfg_done_o,
   output logic [2:0] PADDR_o,
   output logic       PSEL_o,
   output logic       PENABLE_o,
   output logic       PWRITE_o,
   output logic [7:0] PWDATA_o,
   input  logic [7:0] PRDATA_i,
   input  logic       PREADY_i,
   input  logic       PSLVERR_i
);

   localparam int CNT_W = $clog2(POLL_LIMIT + 1);
   localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_LIMIT - 1);

   localparam logic [2:0] ADDR_CR1 = 3'd0;
   localparam logic [2:0] ADDR_CR2 = 3'd1;
   localparam logic [2:0] ADDR_BR  = 3'd2;
   localparam logic [2:0] ADDR_SR  = 3'd3;
   localparam logic [2:0] ADDR_DR  = 3'd5;

   typedef enum logic [3:0] {
      CFG_CR1, CFG_CR2, CFG_BR, CFG_ERR, IDLE, WR_DR, POLL_SR, RD_DR, DONE
   } state_t;

   typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

   state_t             state_reg, state_next;
   phase_t             phase_reg, phase_next;
   logic               psel_reg, psel_next;
   logic               penable_reg, penable_next;
   logic [2:0]         paddr_reg, paddr_next;
   logic               pwrite_reg, pwrite_next;
   logic [7:0]         pwdata_reg, pwdata_next;
   logic [1:0]         gnt_reg, gnt_next;
   logic [1:0]         done_reg, done_next;
   logic               err_reg, err_next;
   logic [7:0]         rx_reg, rx_next;
   logic               cfg_done_reg, cfg_done_next;
   logic               last_reg, last_next;
   logic [7:0]         tx_reg, tx_next;
   logic [CNT_W-1:0]   poll_cnt_reg, poll_cnt_next;

   logic               apb_active, xfer_done, winner;
   logic [2:0]         bus_addr;
   logic               bus_write;
   logic [7:0]         bus_wdata;
   logic               finish, finish_err;
   logic [7:0]         finish_rx;

   always_ff @(posedge PCLK or negedge PRESET_n) begin
      if (!PRESET_n) begin
         state_reg    <= CFG_CR1;
         phase_reg    <= PH_IDLE;
         psel_reg     <= 1'b0;
         penable_reg  <= 1'b0;
         paddr_reg    <= '0;
         pwrite_reg   <= 1'b0;
         pwdata_reg   <= '0;
         gnt_reg      <= '0;
         done_reg     <= '0;
         err_reg      <= 1'b0;
         rx_reg       <= '0;
         cfg_done_reg <= 1'b0;
         last_reg     <= 1'b0;
         tx_reg       <= '0;
         poll_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         phase_reg    <= phase_next;
         psel_reg     <= psel_next;
         penable_reg  <= penable_next;
         paddr_reg    <= paddr_next;
         pwrite_reg   <= pwrite_next;
         pwdata_reg   <= pwdata_next;
         gnt_reg      <= gnt_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
         rx_reg       <= rx_next;
         cfg_done_reg <= cfg_done_next;
         last_reg     <= last_next;
         tx_reg       <= tx_next;
         poll_cnt_reg <= poll_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      phase_next    = phase_reg;
      psel_next     = psel_reg;
      penable_next  = penable_reg;
      paddr_next    = paddr_reg;
      pwrite_next   = pwrite_reg;
      pwdata_next   = pwdata_reg;
      gnt_next      = gnt_reg;
      done_next     = '0;
      err_next      = 1'b0;
      rx_next       = rx_reg;
      cfg_done_next = cfg_done_reg;
      last_next     = last_reg;
      tx_next       = tx_reg;
      poll_cnt_next = poll_cnt_reg;
      apb_active    = 1'b0;
      winner        = 1'b0;
      bus_addr      = ADDR_CR1;
      bus_write     = 1'b0;
      bus_wdata     = '0;
      finish        = 1'b0;
      finish_err    = 1'b0;
      finish_rx     = '0;
      xfer_done     = (phase_reg == PH_ACCESS) && PREADY_i;

      case (state_reg)
         CFG_CR1: begin
            apb_active = 1'b1;
            bus_addr   = ADDR_CR1;
            bus_write  = 1'b1;
            bus_wdata  = CR1_INIT;
            if (xfer_done) state_next = PSLVERR_i ? CFG_ERR : CFG_CR2;
         end
         CFG_CR2: begin
            apb_active = 1'b1;
            bus_addr   = ADDR_CR2;
            bus_write  = 1'b1;
            bus_wdata  = CR2_INIT;
            if (xfer_done) state_next = PSLVERR_i ? CFG_ERR : CFG_BR;
         end
         CFG_BR: begin
            apb_active = 1'b1;
            bus_addr   = ADDR_BR;
            bus_write  = 1'b1;
            bus_wdata  = BR_INIT;
            if (xfer_done) begin
               state_next    = PSLVERR_i ? CFG_ERR : IDLE;
               cfg_done_next = !PSLVERR_i;
            end
         end
         CFG_ERR: state_next = CFG_ERR;
         IDLE: begin
            // With both requesting, the one not served last wins
            if (req_i != 2'b00) begin
               winner     = (req_i == 2'b11) ? !last_reg : req_i[1];
               gnt_next   = winner ? 2'b10 : 2'b01;
               last_next  = winner;
               tx_next    = winner ? tx1_i : tx0_i;
               state_next = WR_DR;
            end
         end
         WR_DR: begin
            apb_active = 1'b1;
            bus_addr   = ADDR_DR;
            bus_write  = 1'b1;
            bus_wdata  = tx_reg;
            if (xfer_done) begin
               if (PSLVERR_i) begin
                  finish     = 1'b1;
                  finish_err = 1'b1;
               end else begin
                  state_next    = POLL_SR;
                  poll_cnt_next = '0;
               end
            end
         end
         POLL_SR: begin
            apb_active = 1'b1;
            bus_addr   = ADDR_SR;
            if (xfer_done) begin
               if (PSLVERR_i || (!PRDATA_i[7] && poll_cnt_reg == POLL_LAST)) begin
                  finish     = 1'b1;
                  finish_err = 1'b1;
               end else if (PRDATA_i[7]) begin
                  state_next = RD_DR;
               end else begin
                  poll_cnt_next = poll_cnt_reg + 1'b1;
               end
            end
         end
         RD_DR: begin
            apb_active = 1'b1;
            bus_addr   = ADDR_DR;
            if (xfer_done) begin
               finish     = 1'b1;
               finish_err = PSLVERR_i;
               finish_rx  = PSLVERR_i ? 8'h00 : PRDATA_i;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = CFG_CR1;
      endcase

      // Shared SETUP/ACCESS sequencing; PH_IDLE leaves one idle bus cycle between transfers
      if (apb_active) begin
         case (phase_reg)
            PH_IDLE: begin
               psel_next    = 1'b1;
               penable_next = 1'b0;
               paddr_next   = bus_addr;
               pwrite_next  = bus_write;
               pwdata_next  = bus_wdata;
               phase_next   = PH_SETUP;
            end
            PH_SETUP: begin
               penable_next = 1'b1;
               phase_next   = PH_ACCESS;
            end
            PH_ACCESS: begin
               if (PREADY_i) begin
                  psel_next    = 1'b0;
                  penable_next = 1'b0;
                  phase_next   = PH_IDLE;
               end
            end
            default: phase_next = PH_IDLE;
         endcase
      end

      if (finish) begin
         state_next = DONE;
         done_next  = gnt_reg;
         gnt_next   = '0;
         err_next   = finish_err;
         rx_next    = finish_rx;
      end
   end

   assign gnt_o      = gnt_reg;
   assign done_o     = done_reg;
   assign rx_data_o  = rx_reg;
   assign err_o      = err_reg;
   assign cfg_done_o = cfg_done_reg;
   assign PADDR_o    = paddr_reg;
   assign PSEL_o     = psel_reg;
   assign PENABLE_o  = penable_reg;
   assign PWRITE_o   = pwrite_reg;
   assign PWDATA_o   = pwdata_reg;

endmodule

// File: tb/tb_spi_apb_txn_sequencer.sv
// Directed bench for spi_apb_txn_sequencer: behavioural APB slave, bus monitor
// with protocol checks, and hand-computed expectations per scenario.
module tb_spi_apb_txn_sequencer;

   logic       PCLK;
   logic       PRESET_n;
   logic [1:0] req_i;
   logic [7:0] tx0_i, tx1_i;
   logic [1:0] gnt_o, done_o;
   logic [7:0] rx_data_o;
   logic       err_o, cfg_done_o;
   logic [2:0] PADDR_o;
   logic       PSEL_o, PENABLE_o, PWRITE_o;
   logic [7:0] PWDATA_o;
   logic [7:0] PRDATA_i;
   logic       PREADY_i, PSLVERR_i;

   spi_apb_txn_sequencer #(.POLL_LIMIT(8)) dut (
      .PCLK(PCLK), .PRESET_n(PRESET_n), .req_i(req_i), .tx0_i(tx0_i), .tx1_i(tx1_i),
      .gnt_o(gnt_o), .done_o(done_o), .rx_data_o(rx_data_o), .err_o(err_o),
      .cfg_done_o(cfg_done_o), .PADDR_o(PADDR_o), .PSEL_o(PSEL_o),
      .PENABLE_o(PENABLE_o), .PWRITE_o(PWRITE_o), .PWDATA_o(PWDATA_o),
      .PRDATA_i(PRDATA_i), .PREADY_i(PREADY_i), .PSLVERR_i(PSLVERR_i)
   );

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   typedef struct {
      logic [2:0] addr;
      logic       wr;
      logic [7:0] wdata;
      logic [7:0] rdata;
      int         acc;
      logic       err;
   } txn_t;

   txn_t txq[$];
   int checks = 0, failures = 0;
   int proto_bad = 0, gnt_bad = 0, gnt_seen = 0;

   // slave configuration, written only by the main sequence
   int         spif_after = 0;
   int         wait_wr_dr = 0;
   logic [7:0] dr_val = 8'h00;
   logic       err_en = 1'b0;
   logic [2:0] err_addr = 3'd0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // APB slave: responds right after each rising edge for the cycle that follows
   initial begin
      int sr_cnt, wait_left;
      sr_cnt = 0;
      wait_left = 0;
      PREADY_i = 1'b0;
      PSLVERR_i = 1'b0;
      PRDATA_i = 8'h00;
      forever begin
         @(posedge PCLK);
         #1;
         PREADY_i = 1'b0;
         PSLVERR_i = 1'b0;
         PRDATA_i = 8'h00;
         if (PSEL_o && !PENABLE_o) begin
            wait_left = (PWRITE_o && PADDR_o == 3'd5) ? wait_wr_dr : 0;
         end else if (PSEL_o && PENABLE_o) begin
            if (wait_left > 0) begin
               wait_left--;
            end else begin
               PREADY_i = 1'b1;
               PSLVERR_i = err_en && (PADDR_o == err_addr);
               if (PWRITE_o && PADDR_o == 3'd5) sr_cnt = 0;
               if (!PWRITE_o && PADDR_o == 3'd3) begin
                  PRDATA_i = (sr_cnt >= spif_after) ? 8'h80 : 8'h00;
                  sr_cnt++;
               end
               if (!PWRITE_o && PADDR_o == 3'd5) PRDATA_i = dr_val;
            end
         end
      end
   end

   // Bus monitor: logs each completed APB transfer and counts protocol violations
   initial begin
      logic       prev_psel, prev_cmpl, s_wr;
      logic [2:0] s_addr;
      logic [7:0] s_wd;
      int         acc;
      txn_t       t;
      prev_psel = 1'b0;
      prev_cmpl = 1'b0;
      s_wr = 1'b0;
      s_addr = 3'd0;
      s_wd = 8'h00;
      acc = 0;
      forever begin
         @(negedge PCLK);
         if (gnt_o != 2'b00) gnt_seen++;
         if (gnt_o == 2'b11) gnt_bad++;
         if (PENABLE_o && !PSEL_o) proto_bad++;
         if (prev_cmpl && PSEL_o) proto_bad++;
         if (PSEL_o && !PENABLE_o) begin
            s_addr = PADDR_o;
            s_wr = PWRITE_o;
            s_wd = PWDATA_o;
            acc = 0;
         end else if (PSEL_o && PENABLE_o) begin
            if (!prev_psel) proto_bad++;
            if (PADDR_o !== s_addr || PWRITE_o !== s_wr || PWDATA_o !== s_wd) proto_bad++;
            acc++;
            if (PREADY_i) begin
               t.addr = PADDR_o;
               t.wr = PWRITE_o;
               t.wdata = PWDATA_o;
               t.rdata = PRDATA_i;
               t.acc = acc;
               t.err = PSLVERR_i;
               txq.push_back(t);
               $display("APB %s addr=%0d wdata=%02h rdata=%02h access_cycles=%0d slverr=%0b",
                        t.wr ? "WR" : "RD", t.addr, t.wdata, t.rdata, t.acc, t.err);
            end
         end
         prev_cmpl = PSEL_o && PENABLE_o && PREADY_i;
         prev_psel = PSEL_o;
      end
   end

   function automatic int count_txn(input int base, input logic [2:0] a, input logic wr);
      int n = 0;
      for (int i = base; i < txq.size(); i++)
         if (txq[i].addr == a && txq[i].wr == wr) n++;
      return n;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_psel"}, {PSEL_o, PENABLE_o, PWRITE_o}, 0);
      check_val({tag, "_paddr"}, PADDR_o, 0);
      check_val({tag, "_pwdata"}, PWDATA_o, 0);
      check_val({tag, "_gnt_done"}, {gnt_o, done_o}, 0);
      check_val({tag, "_err_cfg"}, {err_o, cfg_done_o}, 0);
      check_val({tag, "_rx"}, rx_data_o, 0);
   endtask

   task automatic wait_done(input int budget, output logic [1:0] d, output logic [7:0] rx,
                            output logic e, output logic [1:0] g);
      int   n;
      logic got;
      n = 0;
      got = 1'b0;
      d = 2'b00;
      rx = 8'h00;
      e = 1'b0;
      g = 2'b00;
      while (!got && n < budget) begin
         @(negedge PCLK);
         if (gnt_o != 2'b00) g = gnt_o;
         if (done_o != 2'b00) begin
            got = 1'b1;
            d = done_o;
            rx = rx_data_o;
            e = err_o;
            check_val("gnt_clr_at_done", gnt_o, 0);
         end
         n++;
      end
      check_val("done_seen", got, 1);
   endtask

   initial begin
      logic [1:0] d, g;
      logic [7:0] rx;
      logic       e;
      int         base, n, wr_seen;
      logic [1:0] exp_g [3];
      logic [7:0] exp_wd [3];
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
      exp_wd[0] = 8'h11; exp_wd[1] = 8'h22; exp_wd[2] = 8'h11;

      PRESET_n = 1'b0;
      req_i = 2'b00;
      tx0_i = 8'h00;
      tx1_i = 8'h00;
      repeat (3) @(negedge PCLK);
      check_reset_outputs("reset");

      // Start-up configuration with zero wait states
      base = txq.size();
      PRESET_n = 1'b1;
      n = 0;
      while (!cfg_done_o && n < 100) begin
         @(negedge PCLK);
         n++;
      end
      check_val("cfg_done", cfg_done_o, 1);
      check_val("cfg_txn_count", txq.size() - base, 3);
      if (txq.size() - base >= 3) begin
         check_val("cfg_cr1", {txq[base].wr, txq[base].addr, txq[base].wdata}, {1'b1, 3'd0, 8'hFB});
         check_val("cfg_cr2", {txq[base+1].wr, txq[base+1].addr, txq[base+1].wdata}, {1'b1, 3'd1, 8'hD0});
         check_val("cfg_br", {txq[base+2].wr, txq[base+2].addr, txq[base+2].wdata}, {1'b1, 3'd2, 8'h01});
         check_val("cfg_acc", txq[base].acc + txq[base+1].acc + txq[base+2].acc, 3);
      end

      // Requester 0: SPIF on 4th SR read, tx change after grant must be ignored
      base = txq.size();
      spif_after = 3;
      dr_val = 8'hAB;
      req_i = 2'b01;
      tx0_i = 8'hAA;
      @(negedge PCLK);
      tx0_i = 8'h55;
      wait_done(200, d, rx, e, g);
      req_i = 2'b00;
      check_val("t1_gnt", g, 2'b01);
      check_val("t1_done", d, 2'b01);
      check_val("t1_rx", rx, 8'hAB);
      check_val("t1_err", e, 0);
      check_val("t1_sr_reads", count_txn(base, 3'd3, 1'b0), 4);
      check_val("t1_dr_reads", count_txn(base, 3'd5, 1'b0), 1);
      if (txq.size() > base) check_val("t1_pwdata", txq[base].wdata, 8'hAA);
      @(negedge PCLK);
      check_val("t1_done_pulse", done_o, 0);

      // Requester 1 with PREADY low for 4 ACCESS cycles on the DR write
      base = txq.size();
      spif_after = 0;
      wait_wr_dr = 4;
      dr_val = 8'hC3;
      tx1_i = 8'h3C;
      req_i = 2'b10;
      wait_done(200, d, rx, e, g);
      req_i = 2'b00;
      wait_wr_dr = 0;
      check_val("t2_done", d, 2'b10);
      check_val("t2_rx", rx, 8'hC3);
      check_val("t2_err", e, 0);
      if (txq.size() > base) begin
         check_val("t2_wr_acc", txq[base].acc, 5);
         check_val("t2_pwdata", txq[base].wdata, 8'h3C);
      end

      // Both requesting: round robin continues from requester 1 served last
      base = txq.size();
      dr_val = 8'h5A;
      tx0_i = 8'h11;
      tx1_i = 8'h22;
      req_i = 2'b11;
      for (int k = 0; k < 3; k++) begin
         wait_done(200, d, rx, e, g);
         if (k == 2) req_i = 2'b00;
         check_val($sformatf("rr_gnt%0d", k), g, exp_g[k]);
         check_val($sformatf("rr_done%0d", k), d, exp_g[k]);
         check_val($sformatf("rr_rx%0d", k), rx, 8'h5A);
      end
      wr_seen = 0;
      for (int i = base; i < txq.size(); i++) begin
         if (txq[i].wr && wr_seen < 3) begin
            check_val($sformatf("rr_pwdata%0d", wr_seen), txq[i].wdata, exp_wd[wr_seen]);
            wr_seen++;
         end
      end
      check_val("rr_wr_count", count_txn(base, 3'd5, 1'b1), 3);

      // SPIF never set: POLL_LIMIT reads then error, rx cleared
      base = txq.size();
      spif_after = 1000;
      req_i = 2'b01;
      wait_done(300, d, rx, e, g);
      req_i = 2'b00;
      check_val("to_done", d, 2'b01);
      check_val("to_err", e, 1);
      check_val("to_rx", rx, 8'h00);
      check_val("to_sr_reads", count_txn(base, 3'd3, 1'b0), 8);
      check_val("to_dr_reads", count_txn(base, 3'd5, 1'b0), 0);
      @(negedge PCLK);
      check_val("to_err_pulse", err_o, 0);

      // PSLVERR on CR2 write: configuration aborts, requests never granted
      PRESET_n = 1'b0;
      repeat (2) @(negedge PCLK);
      check_reset_outputs("rerst");
      spif_after = 0;
      err_en = 1'b1;
      err_addr = 3'd1;
      base = txq.size();
      PRESET_n = 1'b1;
      repeat (40) @(negedge PCLK);
      check_val("cerr_txn_count", txq.size() - base, 2);
      check_val("cerr_br_writes", count_txn(base, 3'd2, 1'b1), 0);
      check_val("cerr_cfg_done", cfg_done_o, 0);
      n = gnt_seen;
      base = txq.size();
      req_i = 2'b11;
      repeat (30) @(negedge PCLK);
      req_i = 2'b00;
      check_val("cerr_no_gnt", gnt_seen - n, 0);
      check_val("cerr_no_apb", txq.size() - base, 0);
      check_val("cerr_done", done_o, 0);

      check_val("apb_protocol", proto_bad, 0);
      check_val("gnt_onehot", gnt_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
